// File: rtl/gray_fifo_ptr_ctrl.sv
// rtl/gray_fifo_ptr_ctrl.sv - single-clock FIFO pointer controller with registered Gray pointer export

// Binary to Gray converter: each Gray bit is the XOR of adjacent binary bits.
module binary_to_gray #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// Pointer controller for a 2^ADDR_WIDTH-entry FIFO. The pointers carry one extra
// wrap bit so that full and empty can be told apart when the addresses match.
module gray_fifo_ptr_ctrl #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic                  push_ack_o,
    output logic                  pop_ack_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    output logic [ADDR_WIDTH:0]   wptr_gray_o,
    output logic [ADDR_WIDTH:0]   rptr_gray_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   usage_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_gray_q, rptr_gray_q;
    logic [PW-1:0] wptr_gray_d, rptr_gray_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    // Status is derived from the registered pointers only, so it changes one cycle after acceptance.
    always_comb begin
        full_o  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                  (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
        empty_o = (wptr_q == rptr_q);
        usage_o = wptr_q - rptr_q;
    end

    // Push and pop are judged independently against the current full/empty state; flush wins.
    always_comb begin
        push_ack_o = push_i & ~full_o  & ~flush_i;
        pop_ack_o  = pop_i  & ~empty_o & ~flush_i;
    end

    // Next pointer and sticky error state; rejected requests leave the pointers alone.
    always_comb begin
        wptr_d      = wptr_q + {{ADDR_WIDTH{1'b0}}, push_ack_o};
        rptr_d      = rptr_q + {{ADDR_WIDTH{1'b0}}, pop_ack_o};
        overflow_d  = overflow_q  | (push_i & full_o);
        underflow_d = underflow_q | (pop_i  & empty_o);
        if (flush_i) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    // Gray codes are taken from the next-state pointers so the registered copies track
    // the binary pointers with no extra latency.
    binary_to_gray #(.WIDTH(PW)) u_wptr_gray (
        .bin_i  (wptr_d),
        .gray_o (wptr_gray_d)
    );

    binary_to_gray #(.WIDTH(PW)) u_rptr_gray (
        .bin_i  (rptr_d),
        .gray_o (rptr_gray_d)
    );

    // State registers; reset clears everything immediately, independent of the clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            wptr_gray_q <= '0;
            rptr_gray_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            wptr_gray_q <= wptr_gray_d;
            rptr_gray_q <= rptr_gray_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Outputs driven straight from registers so the exported Gray values cannot glitch.
    always_comb begin
        waddr_o     = wptr_q[ADDR_WIDTH-1:0];
        raddr_o     = rptr_q[ADDR_WIDTH-1:0];
        wptr_gray_o = wptr_gray_q;
        rptr_gray_o = rptr_gray_q;
        overflow_o  = overflow_q;
        underflow_o = underflow_q;
    end

endmodule
